// File: rtl/tx_iq_unpacker.sv
// Unpacks a 64-bit big-endian byte stream of 6-byte I/Q samples into 48-bit words.
// Keeps a 16-byte residue buffer across input words and counts TX underrun cycles.
module tx_iq_unpacker #(
  parameter int UCNT_W = 16
) (
  input  logic              clk122,
  input  logic              reset,
  input  logic [63:0]       S_AXIS_tdata,
  input  logic              S_AXIS_tvalid,
  output logic              S_AXIS_tready,
  output logic [47:0]       M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  input  logic              M_AXIS_tready,
  input  logic              flush,
  input  logic              tx_enable,
  output logic [UCNT_W-1:0] underrun_count,
  input  logic              underrun_clr
);

  logic [7:0]        r_buf [16];
  logic [4:0]        r_cnt;
  logic              r_armed;
  logic [UCNT_W-1:0] r_ucnt;

  logic [7:0]        w_buf_next [16];
  logic [4:0]        w_cnt_next;
  logic [4:0]        w_base;
  logic [3:0]        w_idx;
  logic              w_push;
  logic              w_pop;

  assign S_AXIS_tready  = (r_cnt <= 5'd8) && !reset && !flush;
  assign M_AXIS_tvalid  = (r_cnt >= 5'd6);
  assign M_AXIS_tdata   = M_AXIS_tvalid ?
                          {r_buf[3], r_buf[4], r_buf[5], r_buf[0], r_buf[1], r_buf[2]} : 48'h0;
  assign underrun_count = r_ucnt;

  assign w_push = S_AXIS_tvalid && S_AXIS_tready;
  assign w_pop  = M_AXIS_tvalid && M_AXIS_tready && !flush;

  // New bytes land after the pop shift, so their base slides down by one sample.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_idx  = 4'd0;
    w_base = w_pop ? (r_cnt - 5'd6) : r_cnt;
    for (int i = 0; i < 16; i++) w_buf_next[i] = r_buf[i];
    if (w_pop) begin
      for (int i = 0; i < 10; i++)  w_buf_next[i] = r_buf[i + 6];
      for (int i = 10; i < 16; i++) w_buf_next[i] = 8'h00;
    end
    if (w_push) begin
      for (int n = 0; n < 8; n++) begin
        w_idx             = w_base[3:0] + 4'(n);
        w_buf_next[w_idx] = S_AXIS_tdata[8*n +: 8];
      end
    end
    w_cnt_next = r_cnt + (w_push ? 5'd8 : 5'd0) - (w_pop ? 5'd6 : 5'd0);
  end

  always_ff @(posedge clk122 or posedge reset) begin
    if (reset) begin
      // NOTE: the byte buffer is reset explicitly; zeroed bytes are part of the visible state.
      for (int i = 0; i < 16; i++) r_buf[i] <= 8'h00;
      r_cnt <= 5'd0;
    end else if (flush) begin
      for (int i = 0; i < 16; i++) r_buf[i] <= 8'h00;
      r_cnt <= 5'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_buf <= w_buf_next;
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk122 or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (flush || !tx_enable) begin
      r_armed <= 1'b0;
    end else if (w_pop) begin
      r_armed <= 1'b1;
    end
  end

  // A starved cycle is one where the DUC wants a sample after streaming has started.
  always_ff @(posedge clk122 or posedge reset) begin
    if (reset) begin
      r_ucnt <= '0;
    end else if (underrun_clr) begin
      r_ucnt <= '0;
    end else if (r_armed && tx_enable && M_AXIS_tready && !M_AXIS_tvalid && (r_ucnt != '1)) begin
      r_ucnt <= r_ucnt + 1'b1;
    end
  end

  a_cnt_range : assert property (@(posedge clk122) disable iff (reset) r_cnt <= 5'd16);

endmodule

// File: tb/tb_tx_iq_unpacker.sv
// Directed bench for tx_iq_unpacker: unpacking, backpressure, flush, underrun and reset.
module tb_tx_iq_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [47:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        flush;
  logic        tx_enable;
  logic [15:0] ucnt;
  logic        ucnt_clr;

  int total = 0;
  int bad   = 0;

  logic [63:0] tx_words [$];
  logic [47:0] exp_samp [$];

  localparam logic [63:0] W0  = 64'h0706050403020100;
  localparam logic [63:0] W1  = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] W2  = 64'h1716151413121110;
  localparam logic [63:0] W18 = 64'h1F1E1D1C1B1A1918;
  localparam logic [63:0] W28 = 64'h2F2E2D2C2B2A2928;
  localparam logic [47:0] S0  = 48'h030405000102;
  localparam logic [47:0] S1  = 48'h090A0B060708;
  localparam logic [47:0] S2  = 48'h0F10110C0D0E;
  localparam logic [47:0] S3  = 48'h151617121314;

  tx_iq_unpacker #(.UCNT_W(16)) dut (
    .clk122         (clk),
    .reset          (reset),
    .S_AXIS_tdata   (s_tdata),
    .S_AXIS_tvalid  (s_tvalid),
    .S_AXIS_tready  (s_tready),
    .M_AXIS_tdata   (m_tdata),
    .M_AXIS_tvalid  (m_tvalid),
    .M_AXIS_tready  (m_tready),
    .flush          (flush),
    .tx_enable      (tx_enable),
    .underrun_count (ucnt),
    .underrun_clr   (ucnt_clr)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds queued words and checks every popped sample against the expected queue.
  task automatic run_stream(input int max_cycles);
    int   cyc = 0;
    logic p_push;
    logic p_pop;
    while ((tx_words.size() > 0 || exp_samp.size() > 0) && cyc < max_cycles) begin
      s_tvalid = (tx_words.size() > 0);
      s_tdata  = (tx_words.size() > 0) ? tx_words[0] : 64'h0;
      #1;
      p_push = s_tvalid && s_tready;
      p_pop  = m_tvalid && m_tready;
      if (p_pop) begin
        if (exp_samp.size() > 0) check("stream_sample", 64'(m_tdata), 64'(exp_samp.pop_front()));
        else                     check("extra_sample", 64'(m_tdata), 64'h0);
      end
      if (p_push) void'(tx_words.pop_front());
      tick();
      cyc++;
    end
    s_tvalid = 1'b0;
    check("stream_words_left", 64'(tx_words.size()), 64'd0);
    check("stream_samples_left", 64'(exp_samp.size()), 64'd0);
    tx_words.delete();
    exp_samp.delete();
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    #1;
    check("flush_tready", 64'(s_tready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_tvalid", 64'(m_tvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    s_tdata   = 64'h0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b0;
    flush     = 1'b0;
    tx_enable = 1'b0;
    ucnt_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'h0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_ucnt", 64'(ucnt), 64'd0);
    reset = 1'b0;
    #1;
    check("rel_tready", 64'(s_tready), 64'd1);

    // Two words, sink always ready; 4 bytes remain
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = W0;
    tick();
    check("t1_tvalid", 64'(m_tvalid), 64'd1);
    check("t1_s0", 64'(m_tdata), 64'(S0));
    check("t1_tready8", 64'(s_tready), 64'd1);
    s_tdata = W1;
    tick();
    check("t1_s1", 64'(m_tdata), 64'(S1));
    check("t1_tready10", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0;
    tick();
    check("t1_res_tvalid", 64'(m_tvalid), 64'd0);
    check("t1_res_tdata", 64'(m_tdata), 64'h0);
    check("t1_res_tready", 64'(s_tready), 64'd1);

    // Reset with 4 residue bytes; next word must start a fresh sample
    reset = 1'b1;
    #1;
    check("rmid_tvalid", 64'(m_tvalid), 64'd0);
    check("rmid_tready", 64'(s_tready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rmid_rel_tready", 64'(s_tready), 64'd1);
    check("rmid_rel_tvalid", 64'(m_tvalid), 64'd0);
    tx_words.push_back(W28);
    exp_samp.push_back(48'h2B2C2D28292A);
    run_stream(10);
    flush_pulse();

    // Three words stream into exactly four samples, leaving nothing behind
    tx_words.push_back(W0);  tx_words.push_back(W1);  tx_words.push_back(W2);
    exp_samp.push_back(S0);  exp_samp.push_back(S1);
    exp_samp.push_back(S2);  exp_samp.push_back(S3);
    run_stream(20);
    check("t2_empty_tvalid", 64'(m_tvalid), 64'd0);
    tx_words.push_back(W28);
    exp_samp.push_back(48'h2B2C2D28292A);
    run_stream(10);
    flush_pulse();

    // Backpressure: buffer fills to 16, head sample holds, nothing lost on release
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = W0;
    tick();
    s_tdata = W1;
    tick();
    check("t3_full_tready", 64'(s_tready), 64'd0);
    check("t3_hold", 64'(m_tdata), 64'(S0));
    s_tdata = W2;
    repeat (3) tick();
    check("t3_hold_later", 64'(m_tdata), 64'(S0));
    check("t3_hold_tvalid", 64'(m_tvalid), 64'd1);
    check("t3_still_full", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    tx_words.push_back(W2);
    exp_samp.push_back(S0);  exp_samp.push_back(S1);
    exp_samp.push_back(S2);  exp_samp.push_back(S3);
    run_stream(20);
    check("t3_end_tvalid", 64'(m_tvalid), 64'd0);

    // Flush discards the 06,07 residue
    tx_words.push_back(W0);
    exp_samp.push_back(S0);
    run_stream(10);
    flush_pulse();
    tx_words.push_back(W18);
    exp_samp.push_back(48'h1B1C1D18191A);
    run_stream(10);
    flush_pulse();

    // Underrun counting, clear priority and disarm on tx_enable=0
    tx_enable = 1'b1;
    tx_words.push_back(W0);
    exp_samp.push_back(S0);
    run_stream(10);
    check("u_after_pop", 64'(ucnt), 64'd0);
    repeat (10) tick();
    check("u_ten", 64'(ucnt), 64'd10);
    ucnt_clr = 1'b1;
    tick();
    ucnt_clr  = 1'b0;
    tx_enable = 1'b0;
    check("u_cleared", 64'(ucnt), 64'd0);
    repeat (5) tick();
    check("u_disabled", 64'(ucnt), 64'd0);
    tx_enable = 1'b1;
    repeat (3) tick();
    check("u_disarmed", 64'(ucnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
